// File: rtl/rob_retire_module.sv
// ============================================================================
// rob_retire_module : ROB completion tracker with in-order 4-wide retirement
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_retire_module #(
    parameter int ROB_ID_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_csr_trap_flush,
    input  logic                    i_exu_mis_ls_flush,
    input  logic [ROB_ID_WIDTH-1:0] i_exu_mis_ls_rob_id,
    input  logic [3:0]              i_rob_alloc_vld,
    input  logic [ROB_ID_WIDTH-1:0] i_rob_alloc_id,
    input  logic [3:0]              i_exu_wb_vld,
    input  logic [ROB_ID_WIDTH-1:0] i_exu_wb_rob_id_0,
    input  logic [ROB_ID_WIDTH-1:0] i_exu_wb_rob_id_1,
    input  logic [ROB_ID_WIDTH-1:0] i_exu_wb_rob_id_2,
    input  logic [ROB_ID_WIDTH-1:0] i_exu_wb_rob_id_3,
    input  logic [3:0]              i_exu_wb_excp,
    output logic [3:0]              o_rob_ret_vld,
    output logic [ROB_ID_WIDTH-1:0] o_rob_head_id,
    output logic [ROB_ID_WIDTH-1:0] o_rob_tail_id,
    output logic                    o_rob_excp_vld,
    output logic [ROB_ID_WIDTH-1:0] o_rob_excp_rob_id,
    output logic                    o_rob_empty
);

    localparam int DEPTH = 1 << ROB_ID_WIDTH;
    localparam int SLOTS = 4;

    typedef logic [ROB_ID_WIDTH-1:0] id_t;

    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] done_q,  done_d;
    logic [DEPTH-1:0] excp_q,  excp_d;
    id_t              head_q,  head_d;
    id_t              tail_q,  tail_d;

    id_t              slot_id   [SLOTS];
    id_t              alloc_id  [SLOTS];
    id_t              wb_id     [SLOTS];
    logic [SLOTS-1:0] slot_ok;
    logic [SLOTS-1:0] ret_vld;
    logic [DEPTH-1:0] kill;
    id_t              mis_span;

    function automatic id_t popcnt4(input logic [3:0] m);
        id_t n;
        n = '0;
        for (int k = 0; k < SLOTS; k++) begin
            n = n + id_t'(m[k]);
        end
        return n;
    endfunction

    assign wb_id[0] = i_exu_wb_rob_id_0;
    assign wb_id[1] = i_exu_wb_rob_id_1;
    assign wb_id[2] = i_exu_wb_rob_id_2;
    assign wb_id[3] = i_exu_wb_rob_id_3;

    // Distance from head to the last survivor; anything further is younger and killed.
    assign mis_span = i_exu_mis_ls_rob_id - head_q;

    generate
        for (genvar k = 0; k < SLOTS; k++) begin : g_slot
            assign slot_id[k]  = head_q + id_t'(k);
            assign alloc_id[k] = i_rob_alloc_id + id_t'(k);
            assign slot_ok[k]  = alloc_q[slot_id[k]] & done_q[slot_id[k]] & ~excp_q[slot_id[k]]
                               & (~i_exu_mis_ls_flush | (id_t'(k) <= mis_span));
        end
        for (genvar i = 0; i < DEPTH; i++) begin : g_kill
            assign kill[i] = (id_t'(i) - head_q) > mis_span;
        end
    endgenerate

    always_comb begin
        ret_vld = '0;
        if (!i_csr_trap_flush) begin
            ret_vld[0] = slot_ok[0];
            for (int k = 1; k < SLOTS; k++) begin
                ret_vld[k] = ret_vld[k-1] & slot_ok[k];
            end
        end
    end

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        excp_d  = excp_q;
        head_d  = head_q + popcnt4(ret_vld);
        tail_d  = tail_q;

        for (int k = 0; k < SLOTS; k++) begin
            if (ret_vld[k]) begin
                alloc_d[slot_id[k]] = 1'b0;
                done_d[slot_id[k]]  = 1'b0;
                excp_d[slot_id[k]]  = 1'b0;
            end
        end

        if (i_csr_trap_flush) begin
            alloc_d = '0;
            done_d  = '0;
            excp_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else if (i_exu_mis_ls_flush) begin
            alloc_d = alloc_d & ~kill;
            done_d  = done_d  & ~kill;
            excp_d  = excp_d  & ~kill;
            tail_d  = i_exu_mis_ls_rob_id + id_t'(1);
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                if (i_rob_alloc_vld[k]) begin
                    alloc_d[alloc_id[k]] = 1'b1;
                    done_d[alloc_id[k]]  = 1'b0;
                    excp_d[alloc_id[k]]  = 1'b0;
                end
            end
            tail_d = tail_q + popcnt4(i_rob_alloc_vld);
            // Applied after the alloc clear so a same-cycle writeback to a fresh ID sticks.
            for (int p = 0; p < SLOTS; p++) begin
                if (i_exu_wb_vld[p] && alloc_d[wb_id[p]]) begin
                    done_d[wb_id[p]] = 1'b1;
                    excp_d[wb_id[p]] = i_exu_wb_excp[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q <= '0;
            done_q  <= '0;
            excp_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            excp_q  <= excp_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_rob_ret_vld     = ret_vld;
    assign o_rob_head_id     = head_q;
    assign o_rob_tail_id     = tail_q;
    assign o_rob_excp_vld    = ~i_csr_trap_flush & alloc_q[head_q] & done_q[head_q] & excp_q[head_q];
    assign o_rob_excp_rob_id = head_q;
    assign o_rob_empty       = ~alloc_q[head_q];

    always @(posedge clk) begin
        if (rst_n && !i_csr_trap_flush && !i_exu_mis_ls_flush && (|i_rob_alloc_vld)) begin
            assert (i_rob_alloc_id == tail_q);
            assert (((i_rob_alloc_vld + 4'd1) & i_rob_alloc_vld) == 4'd0);
            for (int k = 0; k < SLOTS; k++) begin
                if (i_rob_alloc_vld[k]) begin
                    assert (!alloc_q[alloc_id[k]]);
                end
            end
        end
    end

endmodule

`default_nettype wire
